// File: rtl/special_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | special_reg_pkg                                                      |
// | Address codes, select encoding and trap kinds for the special regs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package special_reg_pkg;

  localparam logic [4:0] ADDR_SHA = 5'b10011;
  localparam logic [4:0] ADDR_SHB = 5'b10010;
  localparam logic [4:0] ADDR_PSW = 5'b10111;
  localparam logic [4:0] ADDR_CWP = 5'b10110;
  localparam logic [4:0] ADDR_TB  = 5'b10101;
  localparam logic [4:0] ADDR_SWP = 5'b10100;
  localparam logic [4:0] ADDR_PC  = 5'b10001;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_SHA  = 3'd1,
    SEL_SHB  = 3'd2,
    SEL_PSW  = 3'd3,
    SEL_CWP  = 3'd4,
    SEL_TB   = 3'd5,
    SEL_SWP  = 3'd6,
    SEL_PC   = 3'd7
  } reg_sel_e;

  // Bit positions inside the one-hot select vector
  localparam int NUM_SREG = 7;
  localparam int IDX_SHA  = 0;
  localparam int IDX_SHB  = 1;
  localparam int IDX_PSW  = 2;
  localparam int IDX_CWP  = 3;
  localparam int IDX_TB   = 4;
  localparam int IDX_SWP  = 5;
  localparam int IDX_PC   = 6;

  localparam logic TRAP_OFLOW = 1'b0;
  localparam logic TRAP_UFLOW = 1'b1;

endpackage
`default_nettype wire

// File: rtl/special_reg_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | special_reg_bank_if                                                  |
// | Write (destination) and read (source) bus of the special-reg bank.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface special_reg_bank_if #(
  parameter int DATA_W = 32
) ();
  logic [4:0]        dst_addr;
  logic              dst_valid;
  logic [DATA_W-1:0] wr_data;
  logic [4:0]        src_addr;
  logic              src_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_hit;

  modport master (
    output dst_addr, dst_valid, wr_data, src_addr, src_valid,
    input  rd_data, rd_valid, rd_hit
  );

  modport slave (
    input  dst_addr, dst_valid, wr_data, src_addr, src_valid,
    output rd_data, rd_valid, rd_hit
  );
endinterface
`default_nettype wire

// File: rtl/sreg_addr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sreg_addr_decode                                                     |
// | Combinational 5-bit register code to one-hot select plus mapped flag.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sreg_addr_decode
  import special_reg_pkg::*;
(
  input  wire logic [4:0]          addr,
  output logic      [NUM_SREG-1:0] sel_oh,
  output logic                     mapped
);

  reg_sel_e w_sel;

  always_comb begin
    w_sel = SEL_NONE;
    case (addr)
      ADDR_SHA: w_sel = SEL_SHA;
      ADDR_SHB: w_sel = SEL_SHB;
      ADDR_PSW: w_sel = SEL_PSW;
      ADDR_CWP: w_sel = SEL_CWP;
      ADDR_TB:  w_sel = SEL_TB;
      ADDR_SWP: w_sel = SEL_SWP;
      ADDR_PC:  w_sel = SEL_PC;
      default:  w_sel = SEL_NONE;
    endcase
  end

  always_comb begin
    sel_oh = '0;
    case (w_sel)
      SEL_SHA: sel_oh[IDX_SHA] = 1'b1;
      SEL_SHB: sel_oh[IDX_SHB] = 1'b1;
      SEL_PSW: sel_oh[IDX_PSW] = 1'b1;
      SEL_CWP: sel_oh[IDX_CWP] = 1'b1;
      SEL_TB:  sel_oh[IDX_TB]  = 1'b1;
      SEL_SWP: sel_oh[IDX_SWP] = 1'b1;
      SEL_PC:  sel_oh[IDX_PC]  = 1'b1;
      default: sel_oh = '0;
    endcase
    mapped = (w_sel != SEL_NONE);
  end

endmodule
`default_nettype wire

// File: rtl/special_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | special_reg_bank                                                     |
// | Seven special registers with registered reads and window pointer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module special_reg_bank
  import special_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WIN_W  = 3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  special_reg_bank_if.slave      bus,
  input  wire logic              call,
  input  wire logic              ret,
  output logic                   win_trap,
  output logic                   trap_uflow,
  input  wire logic              pc_inc,
  output logic      [DATA_W-1:0] pc_out,
  output logic      [DATA_W-1:0] psw_out,
  output logic      [WIN_W-1:0]  cwp_out
);

  localparam logic [DATA_W-1:0] c_pc_step = DATA_W'(4);

  logic [NUM_SREG-1:0] w_dst_oh, w_src_oh, w_we;
  logic                w_dst_mapped, w_src_mapped;

  sreg_addr_decode u_dst_dec (.addr(bus.dst_addr), .sel_oh(w_dst_oh), .mapped(w_dst_mapped));
  sreg_addr_decode u_src_dec (.addr(bus.src_addr), .sel_oh(w_src_oh), .mapped(w_src_mapped));

  logic [DATA_W-1:0] r_sha, r_shb, r_psw, r_tb, r_pc, r_rd_data;
  logic [WIN_W-1:0]  r_cwp, r_swp;
  logic              r_rd_valid, r_rd_hit, r_win_trap, r_trap_uflow;

  logic [WIN_W-1:0]  w_cwp_dec, w_cwp_inc;
  logic              w_do_call, w_do_ret, w_oflow, w_uflow;
  logic [DATA_W-1:0] w_wr_win, w_rd_mux, w_rd_next;
  logic              w_fwd;

  assign w_we      = w_dst_oh & {NUM_SREG{bus.dst_valid & w_dst_mapped}};
  assign w_do_call = call & ~ret;
  assign w_do_ret  = ret & ~call;
  assign w_cwp_dec = r_cwp - WIN_W'(1);
  assign w_cwp_inc = r_cwp + WIN_W'(1);
  // An explicit CWP write overrides the window move, so it also suppresses the trap
  assign w_oflow   = ~w_we[IDX_CWP] & w_do_call & (w_cwp_dec == r_swp);
  assign w_uflow   = ~w_we[IDX_CWP] & w_do_ret  & (w_cwp_inc == r_swp);
  assign w_wr_win  = {{(DATA_W-WIN_W){1'b0}}, bus.wr_data[WIN_W-1:0]};

  always_comb begin
    w_rd_mux = ({DATA_W{w_src_oh[IDX_SHA]}} & r_sha)
             | ({DATA_W{w_src_oh[IDX_SHB]}} & r_shb)
             | ({DATA_W{w_src_oh[IDX_PSW]}} & r_psw)
             | ({DATA_W{w_src_oh[IDX_CWP]}} & {{(DATA_W-WIN_W){1'b0}}, r_cwp})
             | ({DATA_W{w_src_oh[IDX_TB]}}  & r_tb)
             | ({DATA_W{w_src_oh[IDX_SWP]}} & {{(DATA_W-WIN_W){1'b0}}, r_swp})
             | ({DATA_W{w_src_oh[IDX_PC]}}  & r_pc);
    // Same one-hot on both sides means read and write target one register
    w_fwd = w_src_mapped && (w_src_oh == w_we);
    if (w_fwd)
      w_rd_next = (w_src_oh[IDX_CWP] | w_src_oh[IDX_SWP]) ? w_wr_win : bus.wr_data;
    else
      w_rd_next = w_rd_mux;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sha        <= '0;
      r_shb        <= '0;
      r_psw        <= '0;
      r_tb         <= '0;
      r_pc         <= '0;
      r_cwp        <= '0;
      r_swp        <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_hit     <= 1'b0;
      r_win_trap   <= 1'b0;
      r_trap_uflow <= 1'b0;
    end else begin
      if (w_we[IDX_SHA]) r_sha <= bus.wr_data;
      if (w_we[IDX_SHB]) r_shb <= bus.wr_data;
      if (w_we[IDX_PSW]) r_psw <= bus.wr_data;
      if (w_we[IDX_TB])  r_tb  <= bus.wr_data;
      if (w_we[IDX_SWP]) r_swp <= bus.wr_data[WIN_W-1:0];

      if (w_we[IDX_PC])  r_pc <= bus.wr_data;
      else if (pc_inc)   r_pc <= r_pc + c_pc_step;

      if (w_we[IDX_CWP]) r_cwp <= bus.wr_data[WIN_W-1:0];
      else if (w_do_call) r_cwp <= w_cwp_dec;
      else if (w_do_ret)  r_cwp <= w_cwp_inc;

      r_win_trap   <= w_oflow | w_uflow;
      r_trap_uflow <= w_uflow ? TRAP_UFLOW : TRAP_OFLOW;

      r_rd_valid <= bus.src_valid;
      r_rd_hit   <= bus.src_valid & w_src_mapped;
      if (bus.src_valid) r_rd_data <= w_rd_next;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_hit   = r_rd_hit;
  assign win_trap     = r_win_trap;
  assign trap_uflow   = r_trap_uflow;
  assign pc_out       = r_pc;
  assign psw_out      = r_psw;
  assign cwp_out      = r_cwp;

endmodule
`default_nettype wire

// File: tb/tb_special_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_special_reg_bank                                                  |
// | Scoreboard bench for the special register bank.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_special_reg_bank;

  localparam int DATA_W = 32;
  localparam int WIN_W  = 3;

  localparam logic [4:0] A_SHA = 5'b10011;
  localparam logic [4:0] A_SHB = 5'b10010;
  localparam logic [4:0] A_PSW = 5'b10111;
  localparam logic [4:0] A_CWP = 5'b10110;
  localparam logic [4:0] A_TB  = 5'b10101;
  localparam logic [4:0] A_SWP = 5'b10100;
  localparam logic [4:0] A_PC  = 5'b10001;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              hit;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              call, ret, pc_inc;
  logic              win_trap, trap_uflow;
  logic [DATA_W-1:0] pc_out, psw_out;
  logic [WIN_W-1:0]  cwp_out;

  exp_t q_sb[$];
  exp_t r_exp;
  int   total = 0;
  int   bad   = 0;

  special_reg_bank_if #(.DATA_W(DATA_W)) bus ();

  special_reg_bank #(.DATA_W(DATA_W), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .call       (call),
    .ret        (ret),
    .win_trap   (win_trap),
    .trap_uflow (trap_uflow),
    .pc_inc     (pc_inc),
    .pc_out     (pc_out),
    .psw_out    (psw_out),
    .cwp_out    (cwp_out)
  );

  always #5 clk = ~clk;

  // Read scoreboard: every accepted read is due exactly one edge later
  always @(posedge clk) begin
    #1;
    if (bus.rd_valid === 1'b1) begin
      if (q_sb.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected got rd_valid=1 want no read pending");
      end else begin
        r_exp = q_sb.pop_front();
        total++;
        if (bus.rd_data !== r_exp.data) begin
          bad++;
          $display("FAIL rd_data got=%h want=%h", bus.rd_data, r_exp.data);
        end
        total++;
        if (bus.rd_hit !== r_exp.hit) begin
          bad++;
          $display("FAIL rd_hit got=%b want=%b", bus.rd_hit, r_exp.hit);
        end
      end
    end else if (q_sb.size() != 0) begin
      total++; bad++;
      $display("FAIL rd_missing got rd_valid=%b want 1", bus.rd_valid);
      q_sb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.dst_addr  = '0;
    bus.dst_valid = 1'b0;
    bus.wr_data   = '0;
    bus.src_addr  = '0;
    bus.src_valid = 1'b0;
    call = 1'b0; ret = 1'b0; pc_inc = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [DATA_W-1:0] d);
    bus.dst_addr = a; bus.dst_valid = 1'b1; bus.wr_data = d;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [DATA_W-1:0] d, input logic h);
    exp_t e;
    bus.src_addr = a; bus.src_valid = 1'b1;
    e.data = d; e.hit = h;
    q_sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    total++; if (bus.rd_data !== '0)    begin bad++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
    total++; if (bus.rd_hit !== 1'b0)   begin bad++; $display("FAIL reset_rd_hit got=%b want=0", bus.rd_hit); end
    total++; if (win_trap !== 1'b0)     begin bad++; $display("FAIL reset_win_trap got=%b want=0", win_trap); end
    total++; if (trap_uflow !== 1'b0)   begin bad++; $display("FAIL reset_trap_uflow got=%b want=0", trap_uflow); end
    total++; if (pc_out !== '0)         begin bad++; $display("FAIL reset_pc got=%h want=0", pc_out); end
    total++; if (psw_out !== '0)        begin bad++; $display("FAIL reset_psw got=%h want=0", psw_out); end
    total++; if (cwp_out !== '0)        begin bad++; $display("FAIL reset_cwp got=%h want=0", cwp_out); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk); do_write(A_SHA, 32'hDEADBEEF);
    @(negedge clk); bus.dst_valid = 1'b0; do_read(A_SHA, 32'hDEADBEEF, 1'b1);
    @(negedge clk); bus.src_valid = 1'b0; do_write(A_PSW, 32'hA5A50001);
    @(negedge clk); bus.dst_valid = 1'b0;
    total++; if (psw_out !== 32'hA5A50001) begin bad++; $display("FAIL psw_write got=%h want=a5a50001", psw_out); end
  endtask

  task automatic test_forward_unmapped();
    @(negedge clk); do_write(A_TB, 32'h1234); do_read(A_TB, 32'h1234, 1'b1);
    @(negedge clk); do_write(5'b00011, 32'hFFFFFFFF); do_read(5'b00011, 32'h0, 1'b0);
    @(negedge clk); do_write(A_CWP, 32'hFFFFFFF5); do_read(A_CWP, 32'h5, 1'b1);
    @(negedge clk); bus.dst_valid = 1'b0; do_read(A_TB, 32'h1234, 1'b1);
    total++; if (cwp_out !== 3'd5) begin bad++; $display("FAIL cwp_trunc got=%h want=5", cwp_out); end
    @(negedge clk); do_read(A_SHA, 32'hDEADBEEF, 1'b1);
    @(negedge clk); bus.src_valid = 1'b0;
  endtask

  task automatic test_overflow();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    total++; if (cwp_out !== 3'd0) begin bad++; $display("FAIL ovf_cwp_reset got=%h want=0", cwp_out); end
    @(negedge clk); do_write(A_SWP, 32'd6);
    @(negedge clk); bus.dst_valid = 1'b0; call = 1'b1;
    @(posedge clk); #1;
    total++; if (cwp_out !== 3'd7)  begin bad++; $display("FAIL ovf_cwp1 got=%h want=7", cwp_out); end
    total++; if (win_trap !== 1'b0) begin bad++; $display("FAIL ovf_notrap got=%b want=0", win_trap); end
    @(posedge clk); #1;
    total++; if (cwp_out !== 3'd6)    begin bad++; $display("FAIL ovf_cwp2 got=%h want=6", cwp_out); end
    total++; if (win_trap !== 1'b1)   begin bad++; $display("FAIL ovf_trap got=%b want=1", win_trap); end
    total++; if (trap_uflow !== 1'b0) begin bad++; $display("FAIL ovf_kind got=%b want=0", trap_uflow); end
    @(negedge clk); call = 1'b0;
    @(posedge clk); #1;
    total++; if (win_trap !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b want=0", win_trap); end
  endtask

  task automatic test_underflow_conflicts();
    @(negedge clk); do_write(A_CWP, 32'd5);
    @(negedge clk); bus.dst_valid = 1'b0; ret = 1'b1; do_read(A_CWP, 32'd5, 1'b1);
    @(posedge clk); #1;
    total++; if (cwp_out !== 3'd6)    begin bad++; $display("FAIL udf_cwp got=%h want=6", cwp_out); end
    total++; if (win_trap !== 1'b1)   begin bad++; $display("FAIL udf_trap got=%b want=1", win_trap); end
    total++; if (trap_uflow !== 1'b1) begin bad++; $display("FAIL udf_kind got=%b want=1", trap_uflow); end
    @(negedge clk); bus.src_valid = 1'b0; call = 1'b1; ret = 1'b1;
    @(posedge clk); #1;
    total++; if (cwp_out !== 3'd6)  begin bad++; $display("FAIL both_cwp got=%h want=6", cwp_out); end
    total++; if (win_trap !== 1'b0) begin bad++; $display("FAIL both_trap got=%b want=0", win_trap); end
    // CWP=7 with SWP=6: a bare call would trap, the write must win instead
    @(negedge clk); call = 1'b0; ret = 1'b0; do_write(A_CWP, 32'd7);
    @(negedge clk); call = 1'b1; do_write(A_CWP, 32'd2);
    @(posedge clk); #1;
    total++; if (cwp_out !== 3'd2)  begin bad++; $display("FAIL wr_call_cwp got=%h want=2", cwp_out); end
    total++; if (win_trap !== 1'b0) begin bad++; $display("FAIL wr_call_trap got=%b want=0", win_trap); end
    @(negedge clk); call = 1'b0; do_write(A_CWP, 32'd5);
    @(negedge clk); ret = 1'b1; do_write(A_CWP, 32'd1);
    @(posedge clk); #1;
    total++; if (cwp_out !== 3'd1)  begin bad++; $display("FAIL wr_ret_cwp got=%h want=1", cwp_out); end
    total++; if (win_trap !== 1'b0) begin bad++; $display("FAIL wr_ret_trap got=%b want=0", win_trap); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_pc();
    @(negedge clk); do_write(A_PC, 32'hFFFFFFFC);
    @(negedge clk); bus.dst_valid = 1'b0;
    total++; if (pc_out !== 32'hFFFFFFFC) begin bad++; $display("FAIL pc_write got=%h want=fffffffc", pc_out); end
    pc_inc = 1'b1; do_read(A_PC, 32'hFFFFFFFC, 1'b1);
    @(posedge clk); #1;
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h want=0", pc_out); end
    @(negedge clk); bus.src_valid = 1'b0; do_write(A_PC, 32'h100);
    @(posedge clk); #1;
    total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL pc_wr_wins got=%h want=100", pc_out); end
    @(negedge clk); bus.dst_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (pc_out !== 32'h104) begin bad++; $display("FAIL pc_inc got=%h want=104", pc_out); end
    @(negedge clk); pc_inc = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0]        addrs [6];
    logic [DATA_W-1:0] datas [6];
    logic              hits  [6];
    // SHA and PSW were cleared by the reset inside the overflow scenario
    addrs = '{A_SHB, A_SWP, A_CWP, A_PC, 5'b11111, A_PSW};
    datas = '{32'h0BADF00D, 32'd6, 32'd1, 32'h104, 32'h0, 32'h0};
    hits  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk); do_write(A_SHB, 32'h0BADF00D);
    @(negedge clk); bus.dst_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_read(addrs[i], datas[i], hits[i]);
      @(negedge clk);
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); do_write(A_CWP, 32'd3);
    @(negedge clk); bus.dst_valid = 1'b0; do_read(A_CWP, 32'd3, 1'b1);
    @(posedge clk); #2;
    // src_valid is still high here: this read must be dropped by the reset
    rst_n = 1'b0;
    #1;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL arst_rd_valid got=%b want=0", bus.rd_valid); end
    total++; if (bus.rd_data !== '0)    begin bad++; $display("FAIL arst_rd_data got=%h want=0", bus.rd_data); end
    total++; if (bus.rd_hit !== 1'b0)   begin bad++; $display("FAIL arst_rd_hit got=%b want=0", bus.rd_hit); end
    total++; if (cwp_out !== 3'd0)      begin bad++; $display("FAIL arst_cwp got=%h want=0", cwp_out); end
    total++; if (pc_out !== '0)         begin bad++; $display("FAIL arst_pc got=%h want=0", pc_out); end
    @(negedge clk); bus.src_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL arst_release got rd_valid=%b want=0", bus.rd_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forward_unmapped();
    test_overflow();
    test_underflow_conflicts();
    test_pc();
    test_back_to_back();
    test_async_reset();
    @(negedge clk);
    total++;
    if (q_sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d pending want=0", q_sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
